rec_ctrl: RTL and testbench

REC_CTRL -- requirements
Module: rec_ctrl

---
 rtl/rec_pkg.sv | 15 +
 rtl/rec_addr_cnt.sv | 30 +++
 rtl/rec_ctrl.sv | 108 ++++++++++
 tb/tb_rec_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rec_pkg.sv
// Shared types and default sizing for the sample recorder controller.
package rec_pkg;

  localparam int unsigned ADDR_W_DEF   = 20;
  localparam logic [19:0] MAX_ADDR_DEF = 20'hFFFFF;
  localparam int unsigned DATA_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REC   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rec_addr_cnt.sv
// Write pointer / take length counter; one extra bit so a full memory fits.
module rec_addr_cnt
  import rec_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MAX_ADDR_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  output logic            full_c,
  output logic [ADDR_W:0] count
);

  // Pointer and length are the same value: the next address to write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + (ADDR_W + 1)'(1);
    end
  end

  // High while the pending write lands on the last usable address.
  assign full_c = (count == {1'b0, MAX_ADDR});

endmodule

// File: rtl/rec_ctrl.sv
// Recording controller: streams PCM samples into SRAM with start/pause/stop control.
module rec_ctrl
  import rec_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MAX_ADDR_DEF)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_smp_valid,
  input  logic [DATA_W-1:0] i_smp_data,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic [ADDR_W:0]   o_len,
  output logic [1:0]        o_state,
  output logic              o_done
);

  state_e          state;
  state_e          state_nx;
  logic            write_c;
  logic            start_ok_c;
  logic            clr_c;
  logic            inc_c;
  logic            done_nx_c;
  logic            full_c;
  logic [ADDR_W:0] count;

  // A sample is captured in any REC cycle, even alongside pause/stop.
  assign write_c    = (state == ST_REC) && i_smp_valid;
  // Start only wins when no higher-priority request is present.
  assign start_ok_c = i_start && !i_stop && !i_pause;

  rec_addr_cnt #(
    .ADDR_W   (ADDR_W),
    .MAX_ADDR (MAX_ADDR)
  ) u_cnt (
    .clk    (i_clk),
    .rst    (i_rst),
    .clr    (clr_c),
    .inc    (inc_c),
    .full_c (full_c),
    .count  (count)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic with stop > pause > start priority; a full write ends the take.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_ok_c) state_nx = ST_REC;
      end
      ST_REC: begin
        if (i_stop || (write_c && full_c)) state_nx = ST_DONE;
        else if (i_pause)                  state_nx = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (i_stop)          state_nx = ST_DONE;
        else if (start_ok_c) state_nx = ST_REC;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Counter control and the done-pulse condition.
  always_comb begin
    clr_c     = 1'b0;
    inc_c     = 1'b0;
    done_nx_c = 1'b0;
    inc_c     = write_c;
    clr_c     = ((state == ST_IDLE) || (state == ST_DONE)) && start_ok_c;
    done_nx_c = (state != ST_DONE) && (state_nx == ST_DONE);
  end

  // Registered SRAM write port and done pulse; address/data hold between writes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_we    <= 1'b0;
      o_addr  <= '0;
      o_wdata <= '0;
      o_done  <= 1'b0;
    end else begin
      o_we   <= write_c;
      o_done <= done_nx_c;
      if (write_c) begin
        o_addr  <= count[ADDR_W-1:0];
        o_wdata <= i_smp_data;
      end
    end
  end

  assign o_len   = count;
  assign o_state = state;

endmodule

// File: tb/tb_rec_ctrl.sv
// Self-checking bench for rec_ctrl: directed table, corner sequences, random vs. model.
module tb_rec_ctrl;
  import rec_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, pause = 1'b0, stop = 1'b0, valid = 1'b0;
  logic [15:0] data = '0;

  logic        we    [2];
  logic [19:0] addr  [2];
  logic [15:0] wdata [2];
  logic [20:0] len   [2];
  logic [1:0]  st    [2];
  logic        done  [2];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Instance 0: default sizing. Instance 1: tiny memory to reach the full condition.
  rec_ctrl u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
    .i_smp_valid(valid), .i_smp_data(data),
    .o_we(we[0]), .o_addr(addr[0]), .o_wdata(wdata[0]), .o_len(len[0]),
    .o_state(st[0]), .o_done(done[0])
  );

  rec_ctrl #(.ADDR_W(20), .MAX_ADDR(20'd3)) u_dut_f (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
    .i_smp_valid(valid), .i_smp_data(data),
    .o_we(we[1]), .o_addr(addr[1]), .o_wdata(wdata[1]), .o_len(len[1]),
    .o_state(st[1]), .o_done(done[1])
  );

  // Reference model: phase 0..3 = idle/rec/pause/done, len = samples stored.
  int m_phase [2];
  int m_len   [2];
  int m_max   [2];
  int m_writes[2];

  typedef struct {
    logic        we;
    int          addr;
    logic [15:0] wd;
    int          len;
    int          st;
    logic        done;
  } exp_t;

  typedef struct {
    logic        s, p, t, v;
    logic [15:0] d;
    logic        we;
    logic [19:0] addr;
    logic [15:0] wd;
    logic [20:0] len;
    logic [1:0]  st;
    logic        done;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t model_step(input int k, input logic s, input logic p,
                                      input logic t, input logic v, input logic [15:0] d);
    exp_t e;
    int   prev = m_phase[k];
    e.we = 1'b0; e.addr = 0; e.wd = '0;
    if (m_phase[k] == 1 && v) begin
      e.we = 1'b1; e.addr = m_len[k]; e.wd = d;
      m_len[k]++;
      m_writes[k]++;
    end
    case (m_phase[k])
      0, 3: if (s && !p && !t) begin m_phase[k] = 1; m_len[k] = 0; end
      1: begin
        if (t || m_len[k] > m_max[k]) m_phase[k] = 3;
        else if (p)                   m_phase[k] = 2;
      end
      2: begin
        if (t)            m_phase[k] = 3;
        else if (s && !p) m_phase[k] = 1;
      end
      default: ;
    endcase
    e.len  = m_len[k];
    e.st   = m_phase[k];
    e.done = (prev != 3) && (m_phase[k] == 3);
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin m_phase[k] = 0; m_len[k] = 0; end
  endtask

  // One clock: drive inputs, advance the model, compare both instances after the edge.
  task automatic cycle(input logic s, input logic p, input logic t, input logic v,
                       input logic [15:0] d);
    exp_t e [2];
    start = s; pause = p; stop = t; valid = v; data = d;
    @(posedge clk);
    for (int k = 0; k < 2; k++) e[k] = model_step(k, s, p, t, v, d);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("we[%0d]", k), 32'(we[k]), 32'(e[k].we));
      if (e[k].we) begin
        chk($sformatf("addr[%0d]", k), 32'(addr[k]), 32'(e[k].addr));
        chk($sformatf("wdata[%0d]", k), 32'(wdata[k]), 32'(e[k].wd));
      end
      chk($sformatf("len[%0d]", k), 32'(len[k]), 32'(e[k].len));
      chk($sformatf("state[%0d]", k), 32'(st[k]), 32'(e[k].st));
      chk($sformatf("done[%0d]", k), 32'(done[k]), 32'(e[k].done));
    end
    start = 1'b0; pause = 1'b0; stop = 1'b0; valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_we[%0d]", tag, k), 32'(we[k]), 32'd0);
      chk($sformatf("%s_addr[%0d]", tag, k), 32'(addr[k]), 32'd0);
      chk($sformatf("%s_wdata[%0d]", tag, k), 32'(wdata[k]), 32'd0);
      chk($sformatf("%s_len[%0d]", tag, k), 32'(len[k]), 32'd0);
      chk($sformatf("%s_state[%0d]", tag, k), 32'(st[k]), 32'd0);
      chk($sformatf("%s_done[%0d]", tag, k), 32'(done[k]), 32'd0);
    end
  endtask

  initial begin
    vec_t vecs [10];
    int   w0;

    m_max[0] = 32'hFFFFF; m_max[1] = 3;
    m_writes[0] = 0; m_writes[1] = 0;
    model_reset();

    // Power-on reset.
    #1 rst = 1'b1;
    #1 chk_all_zero("reset");
    #1 rst = 1'b0;

    // Basic take followed by a restart from DONE (expected values for the default instance).
    //            s     p     t     v     d        we    addr   wd       len    st    done
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 20'd0, 16'h0,   21'd0, 2'd1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h1, 1'b1, 20'd0, 16'h1,   21'd1, 2'd1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h2, 1'b1, 20'd1, 16'h2,   21'd2, 2'd1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h3, 1'b1, 20'd2, 16'h3,   21'd3, 2'd1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h4, 1'b1, 20'd3, 16'h4,   21'd4, 2'd1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 20'd3, 16'h4,   21'd4, 2'd3, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 20'd3, 16'h4,   21'd4, 2'd3, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h5, 1'b0, 20'd3, 16'h4,   21'd4, 2'd3, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 20'd3, 16'h4,   21'd0, 2'd1, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hAA, 1'b1, 20'd0, 16'hAA, 21'd1, 2'd1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].s, vecs[i].p, vecs[i].t, vecs[i].v, vecs[i].d);
      chk($sformatf("tbl%0d_we", i), 32'(we[0]), 32'(vecs[i].we));
      chk($sformatf("tbl%0d_addr", i), 32'(addr[0]), 32'(vecs[i].addr));
      chk($sformatf("tbl%0d_wdata", i), 32'(wdata[0]), 32'(vecs[i].wd));
      chk($sformatf("tbl%0d_len", i), 32'(len[0]), 32'(vecs[i].len));
      chk($sformatf("tbl%0d_state", i), 32'(st[0]), 32'(vecs[i].st));
      chk($sformatf("tbl%0d_done", i), 32'(done[0]), 32'(vecs[i].done));
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);

    // Pause and resume: strobes in PAUSE and one riding on the resume are dropped.
    w0 = m_writes[0];
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h10);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h11);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h20);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h21);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h12);
    chk("resume_addr", 32'(addr[0]), 32'd2);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("pause_len", 32'(len[0]), 32'd3);
    chk("pause_writes", 32'(m_writes[0] - w0), 32'd3);

    // Full memory on the small instance: 4 writes, then DONE; extra strobes ignored.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'(16'h30 + i));
      if (i == 3) chk("full_done_pulse", 32'(done[1]), 32'd1);
      if (i >= 4) chk($sformatf("full_nowrite%0d", i), 32'(we[1]), 32'd0);
    end
    chk("full_len", 32'(len[1]), 32'd4);
    chk("full_state", 32'(st[1]), 32'd3);
    chk("full_last_addr", 32'(addr[1]), 32'd3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);

    // Priority: pause+stop with a sample in REC writes the sample and ends in DONE.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'hBEEF);
    chk("prio_we", 32'(we[0]), 32'd1);
    chk("prio_wdata", 32'(wdata[0]), 32'hBEEF);
    chk("prio_state", 32'(st[0]), 32'd3);

    // Asynchronous reset between edges in the middle of a take.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h41);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h42);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1 chk("rst_hold_we", 32'(we[0]), 32'd0);
    rst = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h55);
    chk("post_rst_addr", 32'(addr[0]), 32'd0);

    // Random control and sample traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)),
            16'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
